nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_adder_ctrl_if.sv | 30 +++
 rtl/nibble_serial_adder_ctrl_add4.sv | 22 ++
 rtl/nibble_serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// The slice width is fixed; operand widths are whole multiples of it.
package nibble_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester <-> sequencer bundle: operands and command in, result and status out.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  // Handshake: start is only taken while the block is not busy (IDLE or DONE);
  // the operands, sub and carry_in are captured on that same edge. done is a
  // one-cycle pulse, and sum/carry_out/overflow stay put until the next accept.
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// Combinational 4-bit ripple-carry adder; the one shared slice of the sequencer.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit slice, stepped LSB nibble first.
// Subtract is a + ~b + ~borrow_in, so carry_out=1 means "no borrow".
module nibble_serial_adder_ctrl
  import nibble_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  nibble_serial_adder_ctrl_if.slave   bus,
  output state_t                      fsm_state
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last;

  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_sum;
  logic       sl_co;

  always_comb begin
    accept = bus.start && ((state == IDLE) || (state == DONE));
    last   = (idx == LAST_IDX);
    sl_a   = a_reg[int'(idx) * NIBBLE_W +: NIBBLE_W];
    sl_b   = b_reg[int'(idx) * NIBBLE_W +: NIBBLE_W];
  end

  nibble_add4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_reg),
    .sum  (sl_sum),
    .cout (sl_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.sum       = sum_reg;
    bus.carry_out = carry_out_reg;
    bus.overflow  = overflow_reg;
    fsm_state     = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      idx           <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.sub ? ~bus.carry_in : bus.carry_in;
      idx       <= '0;
    end else if (state == RUN) begin
      sum_reg[int'(idx) * NIBBLE_W +: NIBBLE_W] <= sl_sum;
      carry_reg <= sl_co;
      idx       <= last ? '0 : idx + 1'b1;
      // Flags are latched here so they are already stable while done is high.
      if (last) begin
        carry_out_reg <= sl_co;
        overflow_reg  <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1]) &&
                         (sl_sum[3] != a_reg[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for the nibble-serial adder: directed cases plus random regression at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder_ctrl;
  import nibble_arith_pkg::*;

  logic   clk;
  logic   reset;
  state_t st16;
  state_t st4;
  int     n_cmp;
  int     n_fail;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) f16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  f4 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .bus       (f16.slave),
    .fsm_state (st16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .bus       (f4.slave),
    .fsm_state (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer arithmetic, then signed range check for overflow.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic ci);
    longint mask, half, av, bv, tot, sa, sb, r;
    logic   co, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    if (!s) begin
      tot = av + bv + longint'(ci);
      co  = ((tot >> w) & 1) != 0;
    end else begin
      tot = av - bv - longint'(ci);
      co  = (av >= bv + longint'(ci));
    end
    sa = (av >= half) ? av - (longint'(1) << w) : av;
    sb = (bv >= half) ? bv - (longint'(1) << w) : bv;
    r  = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    ov = (r > half - 1) || (r < -half);
    return {ov, co, 16'(tot & mask)};
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci);
    if (w == 16) begin
      f16.start = st; f16.a = a; f16.b = b; f16.sub = s; f16.carry_in = ci;
    end else begin
      f4.start = st; f4.a = a[3:0]; f4.b = b[3:0]; f4.sub = s; f4.carry_in = ci;
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bz, output logic [15:0] sm,
                        output logic co, output logic ov);
    if (w == 16) begin
      d = f16.done; bz = f16.busy; sm = f16.sum; co = f16.carry_out; ov = f16.overflow;
    end else begin
      d = f4.done; bz = f4.busy; sm = {12'h0, f4.sum}; co = f4.carry_out; ov = f4.overflow;
    end
  endtask

  // One full transaction: operands are scrambled right after accept to prove capture.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ci, input string tag);
    logic [17:0] exp;
    logic        d, bz, co, ov, busy_bad;
    logic [15:0] sm;
    int          lat;
    exp = model(w, a, b, s, ci);
    @(negedge clk);
    drive(w, 1'b1, a, b, s, ci);
    @(negedge clk);
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    lat = 1;
    busy_bad = 1'b0;
    sample(w, d, bz, sm, co, ov);
    while (!d && lat < 20) begin
      if (!bz) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
      sample(w, d, bz, sm, co, ov);
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(w / 4 + 1));
    chk($sformatf("%s busy_run", tag), {31'h0, busy_bad}, 32'h0);
    chk($sformatf("%s busy_done", tag), {31'h0, bz}, 32'h0);
    chk($sformatf("%s sum", tag), {16'h0, sm}, {16'h0, exp[15:0]});
    chk($sformatf("%s carry_out", tag), {31'h0, co}, {31'h0, exp[16]});
    chk($sformatf("%s overflow", tag), {31'h0, ov}, {31'h0, exp[17]});
    @(negedge clk);
    sample(w, d, bz, sm, co, ov);
    chk($sformatf("%s done_pulse", tag), {31'h0, d}, 32'h0);
  endtask

  initial begin
    logic        d, bz, co, ov, seen_done;
    logic [15:0] sm, held;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    sample(16, d, bz, sm, co, ov);
    chk("rst busy", {31'h0, bz}, 32'h0);
    chk("rst done", {31'h0, d}, 32'h0);
    chk("rst sum", {16'h0, sm}, 32'h0);
    chk("rst carry_out", {31'h0, co}, 32'h0);
    chk("rst overflow", {31'h0, ov}, 32'h0);
    chk("rst state16", 32'(st16), 32'(IDLE));
    chk("rst state4", 32'(st4), 32'(IDLE));
    reset = 1'b0;

    run_op(16, 16'h00FF, 16'h0001, 1'b0, 1'b0, "add_basic");
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ripple");
    run_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    run_op(16, 16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow");
    run_op(16, 16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
    run_op(16, 16'h1000, 16'h0FFF, 1'b1, 1'b1, "sub_bin");
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "add_cin");

    // Results must hold while idle.
    sample(16, d, bz, held, co, ov);
    repeat (5) @(negedge clk);
    sample(16, d, bz, sm, co, ov);
    chk("idle hold sum", {16'h0, sm}, {16'h0, held});

    // start during RUN is ignored; start during DONE begins a new op.
    @(negedge clk);
    drive(16, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(16, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    sample(16, d, bz, sm, co, ov);
    chk("ignore busy_t4", {31'h0, bz}, 32'h1);
    @(negedge clk);
    sample(16, d, bz, sm, co, ov);
    chk("ignore done_t5", {31'h0, d}, 32'h1);
    chk("ignore sum_t5", {16'h0, sm}, 32'h2345);
    drive(16, 1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    sample(16, d, bz, sm, co, ov);
    chk("b2b busy_t6", {31'h0, bz}, 32'h1);
    repeat (3) @(negedge clk);
    sample(16, d, bz, sm, co, ov);
    chk("b2b done_t9", {31'h0, d}, 32'h0);
    @(negedge clk);
    sample(16, d, bz, sm, co, ov);
    chk("b2b done_t10", {31'h0, d}, 32'h1);
    chk("b2b sum_t10", {16'h0, sm}, 32'h1011);

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    drive(16, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sample(16, d, bz, sm, co, ov);
    chk("abort busy", {31'h0, bz}, 32'h0);
    chk("abort sum", {16'h0, sm}, 32'h0);
    chk("abort state", 32'(st16), 32'(IDLE));
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (f16.done) seen_done = 1'b1;
    end
    chk("abort no_done", {31'h0, seen_done}, 32'h0);
    run_op(16, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, "post_abort");

    for (int i = 0; i < 1000; i++) begin
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd16");
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(4, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
             1'($urandom), 1'($urandom), "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
